// File: rtl/ifetch_queue.sv
// ifetch_queue
//   Instruction fetch front-end. Holds the fetch PC, presents it to a
//   combinational instruction memory every cycle, and captures each returned
//   word together with its PC in a DEPTH-entry FIFO. Decode drains the FIFO
//   through a valid/ready handshake. A redirect flushes the FIFO and restarts
//   fetch at a new word-aligned PC.
//
//   Optional build macro: IFETCH_FLUSH_CNT_EN adds flush_cnt_o, a saturating
//   count of redirects taken outside reset.
//
// Ports
//   clk_i          clock, all state on rising edge
//   rst_ni         synchronous active-low reset
//   imem_addr_o    byte address to instruction memory (= fetch PC)
//   imem_inst_i    instruction word for imem_addr_o, same cycle
//   redirect_i     flush queue and restart fetch
//   redirect_pc_i  restart PC, bits [1:0] ignored
//   inst_valid_o   FIFO head valid
//   inst_o         instruction at FIFO head
//   pc_o           PC of instruction at FIFO head
//   inst_ready_i   decode accepts the head this cycle
//   flush_cnt_o    redirect count (IFETCH_FLUSH_CNT_EN only)
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        inst_ready_i
`ifdef IFETCH_FLUSH_CNT_EN
  ,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  logic   [31:0]      fetch_pc;
  logic   [AW-1:0]    wr_ptr;
  logic   [AW-1:0]    rd_ptr;
  logic   [AW:0]      count;

  logic pop;
  logic push;

  // A pop offered during a redirect is void; the redirect branch below
  // simply never looks at it, so the head is dropped with the flush.
  assign pop  = inst_valid_o & inst_ready_i;
  // Full queue can still accept a word when the head leaves this cycle.
  assign push = ~redirect_i & ((count < CNT_FULL) | pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mem      <= '0;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: fetch_pc, inst: imem_inst_i};
        wr_ptr      <= wr_ptr + PTR_ONE;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign imem_addr_o  = fetch_pc;
  assign inst_valid_o = (count != '0);
  assign inst_o       = mem[rd_ptr].inst;
  assign pc_o         = mem[rd_ptr].pc;

`ifdef IFETCH_FLUSH_CNT_EN
  logic [31:0] flush_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                flush_cnt <= '0;
    else if (redirect_i && (flush_cnt != '1))   flush_cnt <= flush_cnt + 32'd1;
  end

  assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch front-end that drives the instruction memory's read port and buffers the returned words for the decode stage. It holds the fetch PC, issues one word address per cycle to the combinational instruction memory, and captures each returned instruction with its PC in a small FIFO. Decode consumes the FIFO through a valid/ready handshake. A redirect input (branch/jump resolved downstream) flushes the queue and restarts fetch at a new PC.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch PC loaded at reset; bits [1:0] must be 0.

Ports:
- clk_i  in  1  sole clock; all state updates on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- imem_addr_o  out  32  byte address to instruction memory; always equals fetch_pc.
- imem_inst_i  in  32  instruction word returned combinationally for imem_addr_o in the same cycle.
- redirect_i  in  1  flush queue and restart fetch.
- redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored (treated as 0).
- inst_valid_o  out  1  FIFO head is valid.
- inst_o  out  32  instruction at FIFO head.
- pc_o  out  32  PC of instruction at FIFO head.
- inst_ready_i  in  1  decode accepts head this cycle.

## Operation
- State: fetch_pc[31:0], FIFO storage of DEPTH × {pc[31:0], inst[31:0]}, wr_ptr, rd_ptr, count[$clog2(DEPTH):0].
- pop = inst_valid_o & inst_ready_i.
- push = !redirect_i & (count < DEPTH | pop). Push writes {fetch_pc, imem_inst_i} at wr_ptr; fetch_pc <= fetch_pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- No push: fetch_pc holds; imem_addr_o keeps presenting the same address.
- Full with simultaneous pop: push and pop both occur; count unchanged.
- Redirect (highest priority over push and pop): count, wr_ptr, rd_ptr <= 0; fetch_pc <= {redirect_pc_i[31:2], 2'b00}; no push, and a pop offered that cycle is discarded (handshake considered void, head dropped with the flush).
- Output: inst_valid_o = (count != 0); inst_o/pc_o driven from entry at rd_ptr (registered storage, no combinational path from imem_inst_i or inst_ready_i).
- Pointers wrap modulo DEPTH.

## Timing
- Reset (rst_ni low at an edge): fetch_pc <= RESET_PC, count/pointers <= 0; inst_valid_o = 0, inst_o = 0, pc_o = 0 (storage cleared), imem_addr_o = RESET_PC. Reset overrides redirect. No push during reset cycles (imem returns 0 then).
- Fetch-to-valid latency: 1 cycle. Word addressed in cycle N appears at inst_valid_o in cycle N+1 if queue was empty.
- Redirect in cycle N: inst_valid_o = 0 in N+1; imem_addr_o = new PC in N+1; first new instruction valid in N+2.
- Sustained throughput: 1 instruction/cycle with inst_ready_i held high.
- inst_o/pc_o must stay stable while inst_valid_o=1 and inst_ready_i=0 (unless redirect).
- Reset asserted mid-stream: queue content discarded at that edge, same as above.

## Configuration
- IFETCH_FLUSH_CNT_EN defined: adds output port flush_cnt_o [31:0], reset to 0, incremented by 1 at each edge where redirect_i=1 and rst_ni=1; saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset release, RESET_PC=0, memory word k = 32'h1000_0000+k, inst_ready_i=1 → imem_addr_o 0,4,8,…; from the cycle after release, (pc_o,inst_o) = (0,32'h1000_0000),(4,32'h1000_0001),… one per cycle.
- inst_ready_i=0 for 10 cycles, DEPTH=4 → count reaches 4, imem_addr_o frozen at 32'h10, head stays (0,32'h1000_0000); raising ready resumes in order with no gaps or duplicates.
- Queue full, inst_ready_i=1 in same cycle → one pop and one push, count stays 4, fetch_pc advances by 4.
- Redirect to 32'h0000_0103 with 3 entries queued and ready=1 → next cycle inst_valid_o=0, imem_addr_o=32'h0000_0100; following cycle pc_o=32'h100; dropped entries never appear.
- redirect_pc_i=32'hFFFF_FFF8, ready=1 → pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- With IFETCH_FLUSH_CNT_EN: 3 redirects plus one redirect during rst_ni=0 → flush_cnt_o=3; reset mid-stream → inst_valid_o=0 and flush_cnt_o=0 next cycle.
